// File: rtl/mem_map_pkg.sv
// mem_map_pkg: address map constants shared by the memory responder
package mem_map_pkg;
  localparam logic [3:0] REGION_DMEM = 4'h0;
  localparam logic [3:0] REGION_MMIO = 4'hF;
  localparam logic [27:0] OFF_TXDATA = 28'h000_0000;
  localparam logic [27:0] OFF_STATUS = 28'h000_0004;
  localparam logic [27:0] OFF_CYCLES = 28'h000_0008;
  localparam int STAT_FULL = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_OVF = 2;
  localparam int STAT_CNT_LSB = 8;
endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: byte FIFO for console output; a push into a full FIFO lands only when a pop frees a slot
module tx_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic [7:0] data_in,
  input  logic pop,
  output logic [7:0] data_out,
  output logic full,
  output logic empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CW'(FIFO_DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign data_out = mem[rp];
  // pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  // storage needs no reset; only entries between rp and wp are ever observed
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= data_in;
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: imem/dmem with MMIO console FIFO and cycle counter (counter built only with MEM_RESP_CYCLE_CNT_EN)
module mem_responder
  import mem_map_pkg::*;
#(
  parameter int IMEM_WORDS = 1024,
  parameter int DMEM_WORDS = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic [31:0] iaddr,
  output logic [31:0] idata,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0] we,
  output logic [31:0] drdata,
  output logic [7:0] tx_data,
  output logic tx_valid,
  input  logic tx_ready
);
  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];
  logic [DW-1:0] didx;
  logic is_dmem, is_mmio, tx_push, stat_clr, full, empty, ovf;
  logic [CW-1:0] count;
  logic [31:0] status, cycles;
  logic unused_iaddr;
  assign unused_iaddr = ^{iaddr[31:IW+2], iaddr[1:0]};
  assign idata = imem[iaddr[IW+1:2]];
  assign didx = daddr[DW+1:2];
  assign is_dmem = daddr[31:28] == REGION_DMEM;
  assign is_mmio = daddr[31:28] == REGION_MMIO;
  assign tx_push = is_mmio && daddr[27:0] == OFF_TXDATA && we[0];
  assign stat_clr = is_mmio && daddr[27:0] == OFF_STATUS && we[0] && dwdata[STAT_OVF];
  assign tx_valid = !empty;
  tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(tx_push),
    .data_in(dwdata[7:0]),
    .pop(tx_ready),
    .data_out(tx_data),
    .full(full),
    .empty(empty),
    .count(count)
  );
  // byte-lane data memory write; reads see the pre-write word this cycle
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (is_dmem && we[i]) dmem[didx][8*i +: 8] <= dwdata[8*i +: 8];
  end
  // sticky overflow: set when a push is dropped, cleared by writing bit 2 of STATUS
  always_ff @(posedge clk) begin
    if (reset) ovf <= 1'b0;
    else if (tx_push && full && !(tx_ready && !empty)) ovf <= 1'b1;
    else if (stat_clr) ovf <= 1'b0;
  end
`ifdef MEM_RESP_CYCLE_CNT_EN
  // free-running cycle counter
  always_ff @(posedge clk) begin
    if (reset) cycles <= '0;
    else cycles <= cycles + 32'd1;
  end
`else
  assign cycles = '0;
`endif
  // STATUS word assembly
  always_comb begin
    status = '0;
    status[STAT_FULL] = full;
    status[STAT_EMPTY] = empty;
    status[STAT_OVF] = ovf;
    status[STAT_CNT_LSB +: 8] = 8'(count);
  end
  // read mux across regions; anything unmapped reads zero
  always_comb begin
    drdata = is_dmem ? dmem[didx] :
             !is_mmio ? 32'h0 :
             daddr[27:0] == OFF_STATUS ? status :
             daddr[27:0] == OFF_CYCLES ? cycles : 32'h0;
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder memories, MMIO and console FIFO
module tb_mem_responder;
  localparam logic [31:0] A_TX = 32'hF000_0000;
  localparam logic [31:0] A_ST = 32'hF000_0004;
  localparam logic [31:0] A_CY = 32'hF000_0008;
`ifdef MEM_RESP_CYCLE_CNT_EN
  localparam logic [31:0] CY100 = 32'd100;
`else
  localparam logic [31:0] CY100 = 32'd0;
`endif
  logic clk = 0, reset;
  logic [31:0] iaddr, idata, daddr, dwdata, drdata, d;
  logic [3:0] we;
  logic [7:0] tx_data;
  logic tx_valid, tx_ready;
  logic [7:0] q[$];
  logic movf, m_pop, m_push;
  int n_cmp = 0, n_bad = 0;
  mem_responder dut (
    .clk(clk), .reset(reset), .iaddr(iaddr), .idata(idata),
    .daddr(daddr), .dwdata(dwdata), .we(we), .drdata(drdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] v, input logic [3:0] w);
    daddr = a;
    dwdata = v;
    we = w;
    cyc();
    we = 4'h0;
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    daddr = a;
    we = 4'h0;
    #1 v = drdata;
  endtask
  // reference FIFO model: applies the driven push/pop/clear at each edge
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      movf = 1'b0;
    end else begin
      m_pop = tx_ready && q.size() != 0;
      m_push = daddr == A_TX && we[0];
      if (m_push && q.size() == 8 && !m_pop) movf = 1'b1;
      if (m_pop) q.delete(0);
      if (m_push && q.size() < 8) q.push_back(dwdata[7:0]);
      if (daddr == A_ST && we[0] && dwdata[2]) movf = 1'b0;
    end
  end
  // compare the FIFO outputs against the model mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      chk("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
      if (q.size() != 0 && tx_ready) chk("tx_data", 32'(tx_data), 32'(q[0]));
    end
  end
  initial begin
    reset = 1; tx_ready = 0; we = 0; daddr = 0; dwdata = 0; iaddr = 0; movf = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    rd(A_CY, d); chk("reset_cycles", d, 32'h0);
    rd(A_ST, d); chk("reset_status", d, 32'h0000_0002);
    dut.imem[5] = 32'hDEAD_BEEF;
    dut.imem[6] = 32'h1234_5678;
    iaddr = 32'h17; #1 chk("idata_5", idata, 32'hDEAD_BEEF);
    iaddr = 32'h18; #1 chk("idata_6", idata, 32'h1234_5678);
    wr(32'h10, 32'h1122_3344, 4'hF);
    rd(32'h12, d); chk("dmem_full_wr", d, 32'h1122_3344);
    daddr = 32'h10; dwdata = 32'hAABB_CCDD; we = 4'b0101;
    #1 chk("dmem_pre_write", drdata, 32'h1122_3344);
    cyc();
    we = 0;
    rd(32'h10, d); chk("dmem_lanes_0101", d, 32'h11BB_33DD);
    wr(32'h20, 32'hFFFF_FFFF, 4'hF);
    wr(32'h20, 32'h0000_0000, 4'b1010);
    rd(32'h20, d); chk("dmem_lanes_1010", d, 32'h00FF_00FF);
    for (int i = 0; i < 9; i++) wr(A_TX, 32'h41 + i, 4'h1);
    rd(A_ST, d); chk("status_overflow", d, 32'h0000_0805);
    rd(A_TX, d); chk("txdata_reads_0", d, 32'h0);
    tx_ready = 1;
    wr(A_TX, 32'h50, 4'h1);
    tx_ready = 0;
    rd(A_ST, d); chk("status_full_pushpop", d, 32'h0000_0805);
    wr(A_ST, 32'h0000_0003, 4'h1);
    rd(A_ST, d); chk("status_no_clear", d, 32'h0000_0805);
    wr(A_ST, 32'h0000_0004, 4'h1);
    rd(A_ST, d); chk("status_ovf_clear", d, 32'h0000_0801);
    tx_ready = 1;
    repeat (10) cyc();
    tx_ready = 0;
    rd(A_ST, d); chk("status_drained", d, 32'h0000_0002);
    tx_ready = 1;
    wr(A_TX, 32'h5A, 4'h1);
    cyc();
    tx_ready = 0;
    for (int i = 0; i < 4; i++) wr(A_TX, 32'h61 + i, 4'h1);
    tx_ready = 1;
    cyc();
    tx_ready = 0;
    rd(A_ST, d); chk("status_three", d, 32'h0000_0300);
    daddr = A_TX; dwdata = 32'h77; we = 4'h1; tx_ready = 1; reset = 1;
    cyc();
    reset = 0; we = 0; tx_ready = 0;
    rd(A_CY, d); chk("midreset_cycles", d, 32'h0);
    rd(A_ST, d); chk("midreset_status", d, 32'h0000_0002);
    rd(32'h10, d); chk("midreset_dmem", d, 32'h11BB_33DD);
    #2 chk("midreset_txvalid", 32'(tx_valid), 32'h0);
    cyc();
    rd(32'h2000_0000, d); chk("unmapped_rd", d, 32'h0);
    rd(32'hF000_000C, d); chk("mmio_hole_rd", d, 32'h0);
    wr(32'h2000_0010, 32'hFFFF_FFFF, 4'hF);
    wr(32'hF000_000C, 32'hFFFF_FFFF, 4'hF);
    rd(32'h10, d); chk("unmapped_wr_ignored", d, 32'h11BB_33DD);
    rd(A_ST, d); chk("hole_wr_ignored", d, 32'h0000_0002);
    reset = 1;
    cyc();
    reset = 0;
    wr(A_CY, 32'hFFFF_FFFF, 4'hF);
    repeat (99) cyc();
    rd(A_CY, d); chk("cycles_100", d, CY100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
